tdc_fine_encode_scheduler: RTL and testbench

Time-multiplexes one shared `TOA_fineEncoder` instance across the three 63-bit thermometer samples (TOA, TOT, CAL) captured per TDC hit. It produces one registered result word per hit with a valid/ready handshake. The block sits between the TDC sample DFF banks and the hit-data formatter in the ETROC2 TDC digital back-end. It also latches the bubble-tolerance level per hit and counts hits that arrive while it is busy.

---
 rtl/tdc_enc_pkg.sv | 17 +
 rtl/TOA_fineEncoder.sv | 27 ++
 rtl/tdc_fine_encode_scheduler.sv | 100 ++++++++++
 tb/tb_tdc_fine_encode_scheduler.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/tdc_enc_pkg.sv
// tdc_enc_pkg: shared widths, scheduler state and result word for the TDC fine-code encode path
package tdc_enc_pkg;
    localparam int RAW_W = 63;
    localparam int BIN_W = 7;

    typedef enum logic [2:0] {IDLE, ENC_TOA, ENC_TOT, ENC_CAL, OUT} enc_state_t;

    typedef struct packed {
        logic [BIN_W-1:0] toa_fine;
        logic [BIN_W-1:0] tot_fine;
        logic [BIN_W-1:0] cal_fine;
        logic [1:0]       toa_berr;
        logic [1:0]       tot_berr;
        logic [1:0]       cal_berr;
        logic             any_berr;
    } fine_result_t;
endpackage

// File: rtl/TOA_fineEncoder.sv
// TOA_fineEncoder: thermometer-to-binary fine encoder; counts ones and flags zeros below the top one
module TOA_fineEncoder
    import tdc_enc_pkg::*;
(
    input  logic [RAW_W-1:0] encode_In,
    input  logic [1:0]       level,
    output logic [BIN_W-1:0] Binary_Out,
    output logic [1:0]       bubbleError
);
    logic [BIN_W-1:0] cnt;
    logic [BIN_W-1:0] top;
    logic [BIN_W-1:0] bub;

    always_comb begin
        cnt = '0;
        top = '0;
        for (int i = 0; i < RAW_W; i++) begin
            cnt = cnt + BIN_W'(encode_In[i]);
            top = encode_In[i] ? BIN_W'(i + 1) : top;
        end
        // bubbles = zeros sitting below the highest set bit
        bub = top - cnt;
    end

    assign Binary_Out  = cnt;
    assign bubbleError = {bub > {{(BIN_W-2){1'b0}}, level}, bub != '0};
endmodule

// File: rtl/tdc_fine_encode_scheduler.sv
// tdc_fine_encode_scheduler: time-multiplexes one shared fine encoder over the TOA, TOT and CAL
// samples of a hit and presents one registered result word with a valid/ready handshake
module tdc_fine_encode_scheduler
    import tdc_enc_pkg::*;
#(
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              hit_valid,
    output logic              hit_ready,
    input  logic [RAW_W-1:0]  toa_raw,
    input  logic [RAW_W-1:0]  tot_raw,
    input  logic [RAW_W-1:0]  cal_raw,
    input  logic [1:0]        level,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BIN_W-1:0]  toa_fine,
    output logic [BIN_W-1:0]  tot_fine,
    output logic [BIN_W-1:0]  cal_fine,
    output logic [1:0]        toa_berr,
    output logic [1:0]        tot_berr,
    output logic [1:0]        cal_berr,
    output logic              any_berr,
    output logic [DROP_W-1:0] drop_cnt,
    output logic [RAW_W-1:0]  enc_in,
    output logic [1:0]        enc_level,
    input  logic [BIN_W-1:0]  enc_bin,
    input  logic [1:0]        enc_berr
);
    enc_state_t   state;
    fine_result_t res;
    logic [RAW_W-1:0] tot_h;
    logic [RAW_W-1:0] cal_h;

    // enc_in and enc_level are themselves the TOA sample and level holding registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            hit_ready <= 1'b1;
            out_valid <= 1'b0;
            res       <= '0;
            tot_h     <= '0;
            cal_h     <= '0;
            enc_in    <= '0;
            enc_level <= 2'd1;
            drop_cnt  <= '0;
        end else begin
            if (hit_valid && !hit_ready && drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
            case (state)
                IDLE: if (hit_valid) begin
                    enc_in    <= toa_raw;
                    tot_h     <= tot_raw;
                    cal_h     <= cal_raw;
                    enc_level <= (level == 2'd0) ? 2'd1 : level;
                    hit_ready <= 1'b0;
                    state     <= ENC_TOA;
                end
                ENC_TOA: begin
                    res.toa_fine <= enc_bin;
                    res.toa_berr <= enc_berr;
                    res.any_berr <= |enc_berr;
                    enc_in       <= tot_h;
                    state        <= ENC_TOT;
                end
                ENC_TOT: begin
                    res.tot_fine <= enc_bin;
                    res.tot_berr <= enc_berr;
                    res.any_berr <= res.any_berr | (|enc_berr);
                    enc_in       <= cal_h;
                    state        <= ENC_CAL;
                end
                ENC_CAL: begin
                    res.cal_fine <= enc_bin;
                    res.cal_berr <= enc_berr;
                    res.any_berr <= res.any_berr | (|enc_berr);
                    enc_in       <= '0;
                    enc_level    <= 2'd1;
                    out_valid    <= 1'b1;
                    state        <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    hit_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign toa_fine = res.toa_fine;
    assign tot_fine = res.tot_fine;
    assign cal_fine = res.cal_fine;
    assign toa_berr = res.toa_berr;
    assign tot_berr = res.tot_berr;
    assign cal_berr = res.cal_berr;
    assign any_berr = res.any_berr;
endmodule

// File: tb/tb_tdc_fine_encode_scheduler.sv
// tb_tdc_fine_encode_scheduler: scheduler plus shared encoder against a bit-counting reference model
module tb_tdc_fine_encode_scheduler;
    import tdc_enc_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic hit_valid = 1'b0;
    logic hit_ready;
    logic [RAW_W-1:0] toa_raw = '0, tot_raw = '0, cal_raw = '0;
    logic [1:0] level = 2'd0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [BIN_W-1:0] toa_fine, tot_fine, cal_fine;
    logic [1:0] toa_berr, tot_berr, cal_berr;
    logic any_berr;
    logic [7:0] drop_cnt;
    logic [RAW_W-1:0] enc_in;
    logic [1:0] enc_level;
    logic [BIN_W-1:0] enc_bin;
    logic [1:0] enc_berr;

    int checks = 0;
    int failures = 0;
    int drops = 0;

    always #5 clk = ~clk;

    tdc_fine_encode_scheduler #(.DROP_W(8)) dut (
        .clk(clk), .rstn(rstn), .hit_valid(hit_valid), .hit_ready(hit_ready),
        .toa_raw(toa_raw), .tot_raw(tot_raw), .cal_raw(cal_raw), .level(level),
        .out_valid(out_valid), .out_ready(out_ready),
        .toa_fine(toa_fine), .tot_fine(tot_fine), .cal_fine(cal_fine),
        .toa_berr(toa_berr), .tot_berr(tot_berr), .cal_berr(cal_berr),
        .any_berr(any_berr), .drop_cnt(drop_cnt),
        .enc_in(enc_in), .enc_level(enc_level), .enc_bin(enc_bin), .enc_berr(enc_berr)
    );

    TOA_fineEncoder u_enc (
        .encode_In(enc_in), .level(enc_level), .Binary_Out(enc_bin), .bubbleError(enc_berr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {berr[1:0], bin[6:0]}: bin = number of ones, bubbles = zeros under the highest one
    function automatic logic [8:0] enc_ref(input logic [RAW_W-1:0] r, input int lvl);
        int ones = 0;
        int zeros = 0;
        bit seen = 0;
        for (int i = RAW_W - 1; i >= 0; i--) begin
            if (r[i]) begin
                ones++;
                seen = 1;
            end else if (seen) zeros++;
        end
        return {zeros > lvl, zeros != 0, 7'(ones)};
    endfunction

    function automatic logic [RAW_W-1:0] rand_therm();
        int n = $urandom_range(0, 63);
        logic [63:0] t = (n == 0) ? 64'd0 : ((64'h1 << n) - 64'd1);
        if ($urandom_range(0, 1) == 1) t = t ^ (64'h1 << $urandom_range(0, 62));
        if ($urandom_range(0, 3) == 0) t = t ^ (64'h1 << $urandom_range(0, 62));
        return t[RAW_W-1:0];
    endfunction

    // accept a hit and walk it to the first out_valid cycle, checking each step
    task automatic do_hit(input logic [RAW_W-1:0] a, input logic [RAW_W-1:0] b,
                          input logic [RAW_W-1:0] c, input logic [1:0] l);
        int el = (l == 2'd0) ? 1 : int'(l);
        logic [8:0] ea = enc_ref(a, el);
        logic [8:0] eb = enc_ref(b, el);
        logic [8:0] ec = enc_ref(c, el);
        check("accept_ready", hit_ready, 1);
        toa_raw = a; tot_raw = b; cal_raw = c; level = l; hit_valid = 1'b1;
        tick();
        hit_valid = 1'b0;
        toa_raw = rand_therm(); tot_raw = rand_therm(); cal_raw = rand_therm();
        level = 2'($urandom_range(0, 3));
        check("enc_in_toa", enc_in, a);
        check("enc_level", enc_level, el);
        check("busy_ready", hit_ready, 0);
        tick();
        check("enc_in_tot", enc_in, b);
        tick();
        check("enc_in_cal", enc_in, c);
        check("early_valid", out_valid, 0);
        tick();
        check("out_valid", out_valid, 1);
        check("toa_fine", toa_fine, ea[6:0]);
        check("tot_fine", tot_fine, eb[6:0]);
        check("cal_fine", cal_fine, ec[6:0]);
        check("toa_berr", toa_berr, ea[8:7]);
        check("tot_berr", tot_berr, eb[8:7]);
        check("cal_berr", cal_berr, ec[8:7]);
        check("any_berr", any_berr, |{ea[8:7], eb[8:7], ec[8:7]});
        check("out_enc_in", enc_in, 0);
        check("out_enc_level", enc_level, 1);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_ready"}, hit_ready, 1);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_fines"}, {toa_fine, tot_fine, cal_fine}, 0);
        check({tag, "_berrs"}, {toa_berr, tot_berr, cal_berr, any_berr}, 0);
        check({tag, "_drop"}, drop_cnt, 0);
        check({tag, "_enc_in"}, enc_in, 0);
        check({tag, "_enc_level"}, enc_level, 1);
    endtask

    initial begin
        logic [BIN_W-1:0] held;
        repeat (3) tick();
        rstn = 1'b1;
        check_idle_zero("reset");

        out_ready = 1'b1;
        do_hit(63'h0000_0000_0000_FFFF, 63'h0000_0000_FFFF_FFFF, 63'h7FFF_FFFF_FFFF_FFFF, 2'd2);
        tick();
        check("single_done_valid", out_valid, 0);
        check("single_done_ready", hit_ready, 1);

        do_hit(63'h0000_0000_0000_FFDF, rand_therm(), rand_therm(), 2'd0);
        tick();

        for (int k = 0; k < 20; k++) begin
            do_hit(rand_therm(), rand_therm(), rand_therm(), 2'($urandom_range(0, 3)));
            tick();
            check("rand_done_ready", hit_ready, 1);
            repeat ($urandom_range(0, 2)) tick();
        end

        out_ready = 1'b0;
        do_hit(rand_therm(), rand_therm(), rand_therm(), 2'd3);
        held = toa_fine;
        for (int k = 0; k < 10; k++) begin
            hit_valid = (k == 1 || k == 4 || k == 7);
            if (hit_valid) drops++;
            tick();
            check("stall_valid", out_valid, 1);
            check("stall_ready", hit_ready, 0);
            check("stall_stable", toa_fine, held);
        end
        hit_valid = 1'b0;
        check("drop_cnt_3", drop_cnt, drops);
        out_ready = 1'b1;
        tick();
        check("stall_release", out_valid, 0);

        out_ready = 1'b0;
        do_hit(rand_therm(), rand_therm(), rand_therm(), 2'd1);
        hit_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            tick();
            drops = (drops < 255) ? drops + 1 : 255;
            if (k == 200) check("drop_mid", drop_cnt, drops);
        end
        check("drop_sat", drop_cnt, 255);
        hit_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("sat_release", hit_ready, 1);

        toa_raw = rand_therm(); tot_raw = rand_therm(); cal_raw = rand_therm();
        level = 2'd3;
        hit_valid = 1'b1;
        tick();
        hit_valid = 1'b0;
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        drops = 0;
        check_idle_zero("midrst");
        do_hit(rand_therm(), rand_therm(), rand_therm(), 2'd2);
        tick();
        check("midrst_after", hit_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
